// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF controller: one shared update datapath walks N_NEURONS membrane states per timestep.
// Optional per-neuron refractory counters are built when LIF_SCHED_REFRACTORY_EN is defined.
module lif_scheduler #(
    parameter int N_NEURONS    = 8,
    parameter int REFRAC_STEPS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    input  logic                         cur_valid,
    input  logic [7:0]                   cur_data,
    output logic                         cur_ready,
    output logic [$clog2(N_NEURONS)-1:0] cur_idx,
    output logic                         spk_valid,
    output logic [$clog2(N_NEURONS)-1:0] spk_id,
    input  logic                         spk_ready,
    input  logic                         cfg_we,
    input  logic [7:0]                   cfg_thresh,
    output logic [15:0]                  step_count,
    input  logic [$clog2(N_NEURONS)-1:0] rd_addr,
    output logic [7:0]                   rd_state
);
    localparam int IW = $clog2(N_NEURONS);

    if (N_NEURONS < 2 || N_NEURONS > 64 || (N_NEURONS & (N_NEURONS - 1)) != 0) begin : g_bad_n
        $error("lif_scheduler: N_NEURONS must be a power of two in 2..64");
    end
    if (REFRAC_STEPS < 1 || REFRAC_STEPS > 15) begin : g_bad_refrac
        $error("lif_scheduler: REFRAC_STEPS must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} fsm_t;

    fsm_t          fsm, fsm_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [7:0]    state [N_NEURONS];
    logic [7:0]    thresh;
    logic [7:0]    s, decay, sat;
    logic [8:0]    sum9;
    logic          fetch_hs, in_refr, fire, last;

    // Datapath works on the old state of the neuron currently addressed.
    assign s        = state[idx];
    assign decay    = (s >> 1) + (s >> 2) + (s >> 3);
    assign sum9     = {1'b0, cur_data} + {1'b0, decay};
    assign sat      = sum9[8] ? 8'hFF : sum9[7:0];
    assign fetch_hs = (fsm == FETCH) && cur_valid;
    assign fire     = !in_refr && (s >= thresh);
    assign last     = (idx == IW'(N_NEURONS - 1));
    assign rd_state = state[rd_addr];

`ifdef LIF_SCHED_REFRACTORY_EN
    logic [3:0] refr [N_NEURONS];

    assign in_refr = (refr[idx] != 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) refr[i] <= 4'd0;
        end else if (fetch_hs) begin
            if (in_refr)   refr[idx] <= refr[idx] - 4'd1;
            else if (fire) refr[idx] <= 4'(REFRAC_STEPS);
        end
    end
`else
    assign in_refr = 1'b0;
`endif

    always_comb begin
        fsm_nxt = fsm;
        idx_nxt = idx;
        case (fsm)
            IDLE: if (start) begin
                fsm_nxt = FETCH;
                idx_nxt = '0;
            end
            FETCH: if (cur_valid) begin
                if (fire)      fsm_nxt = EMIT;
                else if (last) fsm_nxt = DONE;
                else           idx_nxt = idx + 1'b1;
            end
            EMIT: if (spk_ready) begin
                if (last) fsm_nxt = DONE;
                else begin
                    fsm_nxt = FETCH;
                    idx_nxt = idx + 1'b1;
                end
            end
            DONE:    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the FSM state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_ready  <= 1'b0;
            cur_idx    <= '0;
            spk_valid  <= 1'b0;
            spk_id     <= '0;
            thresh     <= 8'd210;
            step_count <= 16'd0;
        end else begin
            fsm       <= fsm_nxt;
            idx       <= idx_nxt;
            busy      <= (fsm_nxt != IDLE);
            done      <= (fsm_nxt == DONE);
            cur_ready <= (fsm_nxt == FETCH);
            cur_idx   <= idx_nxt;
            spk_valid <= (fsm_nxt == EMIT);
            if (fetch_hs && fire)         spk_id     <= idx;
            if (fsm == IDLE && cfg_we)    thresh     <= cfg_thresh;
            if (fsm == DONE)              step_count <= step_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) state[i] <= 8'd0;
        end else if (fetch_hs) begin
            state[idx] <= (fire || in_refr) ? 8'd0 : sat;
        end
    end
endmodule

// File: tb/tb_lif_scheduler.sv
// Directed bench for lif_scheduler: ramp-to-spike, saturation, backpressure, control and reset cases.
module tb_lif_scheduler;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n, start, cur_valid, cfg_we, spk_ready;
    logic [7:0] cur_data, cfg_thresh, rd_state;
    logic [2:0] cur_idx, spk_id, rd_addr;
    logic       busy, done, cur_ready, spk_valid;
    logic [15:0] step_count;

    int         n_chk = 0;
    int         n_pass = 0;
    int         exp_steps = 0;
    int         spk_cnt;
    logic [2:0] spk_last;
    logic [7:0] cur_vec [N];
    int         ramp [6] = '{50, 93, 130, 163, 191, 215};

    lif_scheduler #(.N_NEURONS(N), .REFRAC_STEPS(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .cur_valid(cur_valid), .cur_data(cur_data), .cur_ready(cur_ready), .cur_idx(cur_idx),
        .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
        .cfg_we(cfg_we), .cfg_thresh(cfg_thresh), .step_count(step_count),
        .rd_addr(rd_addr), .rd_state(rd_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic rd(input int a, output int v);
        rd_addr = 3'(a);
        #1;
        v = int'(rd_state);
    endtask

    task automatic set_thresh(input logic [7:0] t);
        cfg_we = 1'b1;
        cfg_thresh = t;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One timestep; stall = cycles spk_ready is held low per spike, poke = cycle to assert start+cfg_we.
    task automatic do_step(input int stall, input int poke, output int done_cyc);
        int st;
        st = 0;
        spk_cnt = 0;
        done_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 200; c++) begin
            start      = (c == poke);
            cfg_we     = (c == poke);
            cfg_thresh = 8'd0;
            cur_valid  = 1'b1;
            cur_data   = cur_vec[cur_idx];
            spk_ready  = 1'b0;
            if (spk_valid) begin
                if (st == 0) begin
                    spk_cnt++;
                    spk_last = spk_id;
                end else begin
                    check("hold_id", int'(spk_id), int'(spk_last));
                    check("hold_cur_ready", int'(cur_ready), 0);
                end
                if (st >= stall) begin
                    spk_ready = 1'b1;
                    st = 0;
                end else st++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0; cur_valid = 1'b0; spk_ready = 1'b0;
        exp_steps++;
        check("done_seen", int'(done_cyc > 0), 1);
        check("busy_after", int'(busy), 0);
        check("done_one_cycle", int'(done), 0);
        check("step_count", int'(step_count), exp_steps);
    endtask

    initial begin
        int v, dc;
        rst_n = 1'b0; start = 1'b0; cur_valid = 1'b0; cur_data = 8'd0; spk_ready = 1'b0;
        cfg_we = 1'b0; cfg_thresh = 8'd0; rd_addr = 3'd0;
        for (int i = 0; i < N; i++) cur_vec[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_busy", int'(busy), 0);
        check("rst_spk_valid", int'(spk_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_cur_ready", int'(cur_ready), 0);
        check("rst_step_count", int'(step_count), 0);
        for (int i = 0; i < N; i++) begin
            rd(i, v);
            check("rst_state", v, 0);
        end

        // Ramp neuron 0 with constant current 50 up to threshold 210.
        cur_vec[0] = 8'd50;
        for (int s = 0; s < 6; s++) begin
            do_step(0, -1, dc);
            if (s == 0) check("min_step_done_cycle", dc, N + 1);
            check("ramp_spikes", spk_cnt, 0);
            rd(0, v);
            check("ramp_state", v, ramp[s]);
        end
        do_step(0, -1, dc);
        check("fire_count", spk_cnt, 1);
        check("fire_id", int'(spk_last), 0);
        check("fire_done_cycle", dc, N + 2);
        rd(0, v);
        check("fire_state_reset", v, 0);
`ifdef LIF_SCHED_REFRACTORY_EN
        for (int s = 0; s < 2; s++) begin
            do_step(0, -1, dc);
            check("refr_spikes", spk_cnt, 0);
            rd(0, v);
            check("refr_state", v, 0);
        end
`endif
        do_step(0, -1, dc);
        rd(0, v);
        check("post_fire_state", v, 50);

        // Backpressure: neuron 0 at 50 spikes against threshold 50, sink stalls 5 cycles.
        set_thresh(8'd50);
        do_step(5, -1, dc);
        check("bp_count", spk_cnt, 1);
        check("bp_id", int'(spk_last), 0);
        check("bp_done_cycle", dc, N + 2 + 5);
        rd(0, v);
        check("bp_state", v, 0);

        // Saturation and the state == threshold boundary on neuron 3.
        set_thresh(8'd255);
        cur_vec[0] = 8'd0;
        cur_vec[3] = 8'd200;
        do_step(0, -1, dc);
        rd(3, v);
        check("sat_preload", v, 200);
        cur_vec[3] = 8'd255;
        do_step(0, -1, dc);
        rd(3, v);
        check("sat_state", v, 255);
        check("sat_spikes", spk_cnt, 0);
        cur_vec[3] = 8'd0;
        do_step(0, -1, dc);
        check("eq_thresh_count", spk_cnt, 1);
        check("eq_thresh_id", int'(spk_last), 3);
        rd(3, v);
        check("eq_thresh_state", v, 0);

        // start/cfg_we while busy (mid-FETCH, then in the DONE cycle) must be ignored.
        do_step(0, 3, dc);
        check("ctl_mid_done_cycle", dc, N + 1);
        do_step(0, N + 1, dc);
        check("ctl_done_cycle", dc, N + 1);
        do_step(0, -1, dc);
        check("ctl_thresh_kept", spk_cnt, 0);

        // Reset while a spike is pending.
        cur_vec[5] = 8'd77;
        do_step(0, -1, dc);
        rd(5, v);
        check("pre_rst_state", v, 77);
        cur_vec[5] = 8'd0;
        set_thresh(8'd0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cur_valid = 1'b1; cur_data = 8'd0; spk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pend_spk_valid", int'(spk_valid), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; cur_valid = 1'b0;
        check("mrst_busy", int'(busy), 0);
        check("mrst_spk_valid", int'(spk_valid), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_step_count", int'(step_count), 0);
        @(posedge clk); #1;
        check("mrst_no_done", int'(done), 0);
        check("mrst_no_spike", int'(spk_valid), 0);
        rd(5, v);
        check("mrst_state", v, 0);
        exp_steps = 0;
        do_step(0, -1, dc);
        check("mrst_thresh_default", spk_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lif_scheduler.md
# lif_scheduler

Time-multiplexed controller that shares one LIF update datapath among N_NEURONS virtual neurons. Membrane states live in an internal register array. On each `start` the block runs one timestep: it walks neurons 0..N_NEURONS-1, consumes one input current per neuron over a valid/ready stream, and emits one spike event per firing neuron over a second valid/ready stream. It sits between the input-current source and the spike-event sink in the neuron array.

## Interface
- `N_NEURONS`, 8: virtual neurons; power of two, 2..64.
- `REFRAC_STEPS`, 2: refractory length in timesteps. Used only with the refractory feature; range 1..15.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low; clock clk.
- `start` in 1: begin a timestep. Accepted only in IDLE; ignored otherwise.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at the end of a timestep.
- `cur_valid` in 1: input current valid.
- `cur_data` in 8: unsigned current for neuron `cur_idx`.
- `cur_ready` out 1: high in FETCH.
- `cur_idx` out log2(N_NEURONS): index of the neuron being fetched.
- `spk_valid` out 1: spike event valid.
- `spk_id` out log2(N_NEURONS): index of the firing neuron.
- `spk_ready` in 1: sink accepts the spike event.
- `cfg_we` in 1: threshold write strobe. Honoured only in IDLE.
- `cfg_thresh` in 8: new threshold.
- `step_count` out 16: completed timesteps. Wraps at 65535 -> 0.
- `rd_addr` in log2(N_NEURONS): state readback address.
- `rd_state` out 8: combinational read of `state[rd_addr]`.

## Operation
- FSM states: IDLE, FETCH, EMIT, DONE.
- IDLE -> FETCH on `start`; the neuron index `idx` is set to 0.
- FETCH: `cur_ready`=1. On `cur_valid && cur_ready`:
  - `spike = state[idx] >= thresh`, evaluated on the old state.
  - `decay = (s>>1)+(s>>2)+(s>>3)`, where `s = state[idx]`.
  - Next state: `state[idx] <= spike ? 0 : min(255, cur_data + decay)`. The sum is computed 9 bits wide and saturates at 255.
  - If `spike`: go to EMIT with `spk_valid`=1, `spk_id`=idx.
  - Otherwise: if idx==N_NEURONS-1 go to DONE, else idx+1 and stay in FETCH.
- EMIT: `spk_valid` and `spk_id` are held stable until `spk_ready`. On that handshake, advance exactly as the non-spike FETCH exit. `cur_ready`=0 in EMIT.
- DONE: `done`=1 for one cycle, `step_count`+1, then go to IDLE.
- `cfg_we` in IDLE loads `thresh` on the next edge. It is ignored while `busy`.
- Reset values: all `state[]`=0, `thresh`=210, `step_count`=0, FSM=IDLE, idx=0. All outputs are 0, and `cur_ready`=0.
- Reset mid-step: the step is abandoned with no `done` pulse. Any spike already pending is dropped.

## Timing
- Registered outputs: `busy`, `done`, `cur_ready`, `spk_valid`, `spk_id`, `cur_idx`.
- `start` sampled at edge 0 gives FETCH from cycle 1.
- Minimum step with no spikes and `cur_valid` held at 1:
  - FETCH occupies cycles 1..N_NEURONS.
  - `done` is high in cycle N_NEURONS+1.
  - `busy` falls in cycle N_NEURONS+2.
- Each spiking neuron adds at least 1 cycle, plus one cycle per cycle that `spk_ready` is low.
- `start` asserted in the same cycle as `done` is ignored, because the FSM is not in IDLE.
- A `spk_ready` that is high when `spk_valid` first rises completes the handshake in that same cycle.
- The `state[]` write and the `spk_valid` rise land on the same edge.

## Configuration
- `LIF_SCHED_REFRACTORY_EN` defined:
  - Each neuron has a 4-bit refractory counter, reset value 0.
  - On a spike the counter loads REFRAC_STEPS.
  - While the counter is nonzero, the fetched current is still consumed, but the state is forced to 0, no spike is generated, and the counter decrements by 1.
- Macro undefined: no counters exist, and neurons may fire on any step whose old state is >= threshold.

## Test plan
- Reset then idle:
  - `state[0..7]`=0, `thresh`=210, `step_count`=0.
  - `busy`=0, `spk_valid`=0.
- Constant `cur_data`=50 for neuron 0, others 0, `spk_ready`=1, 7 steps:
  - `rd_state(0)` after steps 1..6 = 50, 93, 130, 163, 191, 215.
  - Step 7 emits `spk_id`=0, and the state returns to 0.
- Saturation: preload neuron 3 to 200 using threshold 255 and `cfg_we`, then feed current 255 → `state[3]`=255, no spike.
- Backpressure: neuron 0 spikes while `spk_ready` is held 0 for 5 cycles:
  - `spk_valid`/`spk_id` stay stable and `cur_ready` stays 0.
  - `done` arrives 5 cycles later than the unstalled run.
- Control: `start` and `cfg_we` asserted while busy are ignored. `rst_n` low mid-step clears all state, with no `done` pulse and no spike.
- With `LIF_SCHED_REFRACTORY_EN` and REFRAC_STEPS=2, current 50 for neuron 0:
  - After the step-7 spike, the state stays 0 for steps 8–9.
  - Step 10 gives state 50.
